// File: rtl/gate_pair_sequencer_pkg.sv
// Shared widths, fixed-point scale, component indices and FSM states
// for the 2x2 complex gate sequencer.
package gate_pair_sequencer_pkg;

    localparam int NUMBER_BITS = 37;
    localparam int FRAC_BITS = NUMBER_BITS - 2;
    localparam longint FIX_ONE = 64'sd1 <<< FRAC_BITS;

    localparam int REAL = 0;
    localparam int IMAG = 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/gate_pair_sequencer_if.sv
// Operand/result bundle between a requester and the gate sequencer.
// Arrays are indexed [row][col][REAL:IMAG] and [pair][REAL:IMAG].
interface gate_pair_sequencer_if #(
    parameter int NUMBER_BITS = gate_pair_sequencer_pkg::NUMBER_BITS
);

    logic                          start;
    logic signed [NUMBER_BITS-1:0] gate    [0:1][0:1][0:1];
    logic signed [NUMBER_BITS-1:0] amp_in  [0:1][0:1];
    logic signed [NUMBER_BITS-1:0] amp_out [0:1][0:1];
    logic                          busy;
    logic                          done;

    modport master (
        output start, gate, amp_in,
        input  amp_out, busy, done
    );

    modport slave (
        input  start, gate, amp_in,
        output amp_out, busy, done
    );

endinterface

// File: rtl/gate_pair_sequencer_mul.sv
// Clocked complex fixed-point multiplier: captures x/y on ready, returns
// the rounded product one cycle later and holds available while ready.
module complex_fix_mul_clocked #(
    parameter int NUMBER_BITS = gate_pair_sequencer_pkg::NUMBER_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ready,
    input  logic signed [NUMBER_BITS-1:0] x [0:1],
    input  logic signed [NUMBER_BITS-1:0] y [0:1],
    output logic signed [NUMBER_BITS:0]   out [0:1],
    output logic                          available
);

    localparam int W = NUMBER_BITS;
    localparam int PW = 2 * W + 1;
    localparam int FRAC = W - 2;
    localparam int RE = gate_pair_sequencer_pkg::REAL;
    localparam int IM = gate_pair_sequencer_pkg::IMAG;

    logic signed [W-1:0]  xq [0:1];
    logic signed [W-1:0]  yq [0:1];
    logic signed [PW-1:0] xr, xi, yr, yi;
    logic signed [PW-1:0] full [0:1];
    logic signed [PW-1:0] rnd [0:1];
    logic signed [W:0]    res [0:1];
    logic                 pend;

    // Full-precision complex product, rounded back to Q.35 and clamped
    always_comb begin
        xr = PW'(xq[RE]);
        xi = PW'(xq[IM]);
        yr = PW'(yq[RE]);
        yi = PW'(yq[IM]);
        full[RE] = xr * yr - xi * yi;
        full[IM] = xr * yi + xi * yr;
        for (int p = 0; p < 2; p++) begin
            rnd[p] = (full[p] + (PW'(1) <<< (FRAC - 1))) >>> FRAC;
            if (rnd[p][PW-1:W] == '0 || rnd[p][PW-1:W] == '1)
                res[p] = rnd[p][W:0];
            else if (rnd[p][PW-1])
                res[p] = {1'b1, {W{1'b0}}};
            else
                res[p] = {1'b0, {W{1'b1}}};
        end
    end

    // Capture operands, then publish result; dropping ready rearms
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= 1'b0;
            available <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                xq[p] <= '0;
                yq[p] <= '0;
                out[p] <= '0;
            end
        end else if (!ready) begin
            pend <= 1'b0;
            available <= 1'b0;
        end else if (!pend && !available) begin
            xq <= x;
            yq <= y;
            pend <= 1'b1;
        end else if (pend) begin
            out <= res;
            pend <= 1'b0;
            available <= 1'b1;
        end
    end

endmodule

// File: rtl/gate_pair_sequencer.sv
// Applies a 2x2 complex gate to an amplitude pair with one shared
// multiplier, four products in fixed order, saturating pairwise sums.
module gate_pair_sequencer
    import gate_pair_sequencer_pkg::*;
#(
    parameter int NUMBER_BITS = gate_pair_sequencer_pkg::NUMBER_BITS
) (
    input logic                  clk,
    input logic                  reset,
    gate_pair_sequencer_if.slave bus
);

    localparam int W = NUMBER_BITS;

    state_t              state, nstate;
    logic [1:0]          k;
    logic signed [W-1:0] opg [0:1][0:1][0:1];
    logic signed [W-1:0] opa [0:1][0:1];
    logic signed [W-1:0] mx [0:1];
    logic signed [W-1:0] my [0:1];
    logic signed [W:0]   mout [0:1];
    logic signed [W:0]   prod [0:1];
    logic signed [W:0]   first [0:1];
    logic signed [W-1:0] b0 [0:1];
    logic signed [W+1:0] sum [0:1];
    logic signed [W-1:0] sat [0:1];
    logic                mready;
    logic                mavail;

    // Product k pairs U[k[1]][k[0]] with a[k[0]]
    assign mx = opg[k[1]][k[0]];
    assign my = opa[k[0]];

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    complex_fix_mul_clocked #(
        .NUMBER_BITS(W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ready     (mready),
        .x         (mx),
        .y         (my),
        .out       (mout),
        .available (mavail)
    );

    // Widened sum of the pair's two products, clamped to NUMBER_BITS
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sum[p] = {first[p][W], first[p]} + {prod[p][W], prod[p]};
            if (sum[p][W+1:W-1] == '0 || sum[p][W+1:W-1] == '1)
                sat[p] = sum[p][W-1:0];
            else if (sum[p][W+1])
                sat[p] = {1'b1, {(W-1){1'b0}}};
            else
                sat[p] = {1'b0, {(W-1){1'b1}}};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // Next state and multiplier handshake
    always_comb begin
        nstate = state;
        mready = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) nstate = ISSUE;
            ISSUE: begin
                mready = 1'b1;
                nstate = WAIT;
            end
            WAIT: begin
                mready = 1'b1;
                if (mavail) nstate = GAP;
            end
            GAP:   nstate = (k == 2'd3) ? DONE : ISSUE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Operand latch, product capture and accumulation
    always_ff @(posedge clk) begin
        if (!reset) begin
            k <= '0;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    opg[0][i][p] <= '0;
                    opg[1][i][p] <= '0;
                    opa[i][p] <= '0;
                    bus.amp_out[i][p] <= '0;
                end
                prod[i] <= '0;
                first[i] <= '0;
                b0[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    opg <= bus.gate;
                    opa <= bus.amp_in;
                    k <= '0;
                end
                WAIT: if (mavail) prod <= mout;
                GAP: begin
                    k <= k + 2'd1;
                    if (!k[0]) begin
                        first <= prod;
                    end else if (!k[1]) begin
                        b0 <= sat;
                    end else begin
                        bus.amp_out[0] <= b0;
                        bus.amp_out[1] <= sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pair_sequencer.sv
// Bench for gate_pair_sequencer: fixed vectors, multi-cycle corner
// sequences and random gates against an exact arithmetic model.
module tb_gate_pair_sequencer;
    import gate_pair_sequencer_pkg::*;

    localparam int NB = NUMBER_BITS;
    localparam longint F = FIX_ONE;
    localparam longint A0R = 64'sd13654556672;
    localparam longint A0I = 64'sd20920401920;
    localparam longint A1R = 64'sd25615794176;
    localparam longint A1I = 64'sd6051463168;
    localparam longint S15 = 64'sd51539607552;

    typedef logic [7:0][63:0] gv_t;
    typedef logic [3:0][63:0] av_t;
    typedef struct packed {
        gv_t g;
        av_t a;
        av_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gate_pair_sequencer_if #(.NUMBER_BITS(NB)) bus ();

    gate_pair_sequencer #(.NUMBER_BITS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input longint act,
                       input longint exp, input longint tol);
        longint d;
        d = act - exp;
        n_cmp++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (tol %0d)",
                     nm, act, exp, tol);
        end
    endtask

    task automatic drive(input gv_t g, input av_t a);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    bus.gate[r][c][p] = g[r*4+c*2+p][NB-1:0];
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
                bus.amp_in[c][p] = a[c*2+p][NB-1:0];
    endtask

    function automatic longint outv(input int i);
        return longint'(bus.amp_out[i/2][i%2]);
    endfunction

    function automatic logic [63:0] rv();
        longint v;
        v = longint'({$urandom, $urandom} % 64'd68719476737) - F;
        return v;
    endfunction

    function automatic gv_t rand_g();
        gv_t g;
        for (int i = 0; i < 8; i++) g[i] = rv();
        return g;
    endfunction

    function automatic av_t rand_a();
        av_t a;
        for (int i = 0; i < 4; i++) a[i] = rv();
        return a;
    endfunction

    // Exact b[row] component: sum over col of U[row][col]*a[col]
    function automatic longint model(input gv_t g, input av_t a,
                                     input int row, input int p);
        logic signed [127:0] s, ur, ui, ar, ai, lim;
        s = '0;
        for (int c = 0; c < 2; c++) begin
            ur = 128'($signed(g[row*4+c*2]));
            ui = 128'($signed(g[row*4+c*2+1]));
            ar = 128'($signed(a[c*2]));
            ai = 128'($signed(a[c*2+1]));
            if (p == 0) s = s + ur * ar - ui * ai;
            else        s = s + ur * ai + ui * ar;
        end
        s = s >>> FRAC_BITS;
        lim = 128'sd1 <<< (NB - 1);
        if (s > lim - 1) s = lim - 1;
        if (s < -lim)    s = -lim;
        return longint'(s);
    endfunction

    task automatic run_op(input string nm, input gv_t g, input av_t a,
                          input av_t e, input bit scramble);
        int cyc;
        @(negedge clk);
        drive(g, a);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) drive(rand_g(), rand_a());
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_done", nm), longint'(bus.done), 1, 0);
        chk($sformatf("%s_busy_at_done", nm), longint'(bus.busy), 1, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_out%0d", nm, i), outv(i),
                longint'($signed(e[i])), 12);
        @(negedge clk);
        chk($sformatf("%s_done_1cyc", nm), longint'(bus.done), 0, 0);
        chk($sformatf("%s_busy_after", nm), longint'(bus.busy), 0, 0);
    endtask

    initial begin
        vec_t tbl [4];
        gv_t  gid, gpx, gr;
        av_t  aa, ar, er;
        int   pulses, cyc, first_d, second_d, gap_idle, wide;
        logic prev_done;
        longint seen0;

        reset = 1'b0;
        bus.start = 1'b0;
        drive('0, '0);
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0, 0);
        chk("rst_done", longint'(bus.done), 0, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_out%0d", i), outv(i), 0, 0);
        reset = 1'b1;

        aa = '0;
        aa[0] = A0R; aa[1] = A0I; aa[2] = A1R; aa[3] = A1I;
        gid = '0; gid[0] = F; gid[6] = F;
        gpx = '0; gpx[2] = F; gpx[4] = F;

        tbl[0].g = gid;
        tbl[0].a = aa;
        tbl[0].e = aa;

        tbl[1].g = gpx;
        tbl[1].a = aa;
        tbl[1].e = '0;
        tbl[1].e[0] = A1R; tbl[1].e[1] = A1I;
        tbl[1].e[2] = A0R; tbl[1].e[3] = A0I;

        tbl[2].g = '0; tbl[2].g[0] = A0R; tbl[2].g[1] = A0I;
        tbl[2].a = '0; tbl[2].a[0] = A1R; tbl[2].a[1] = A1I;
        tbl[2].e = '0;
        tbl[2].e[0] = 64'sd6495197059;
        tbl[2].e[1] = 64'sd18001381437;

        tbl[3].g = '0; tbl[3].g[0] = S15; tbl[3].g[2] = S15;
        tbl[3].a = '0; tbl[3].a[0] = S15; tbl[3].a[2] = S15;
        tbl[3].e = '0;
        tbl[3].e[0] = 64'sd68719476735;

        for (int v = 0; v < 4; v++)
            run_op($sformatf("vec%0d", v), tbl[v].g, tbl[v].a,
                   tbl[v].e, 1'b1);

        // Reset while product k=2 is in flight
        @(negedge clk);
        drive(gid, aa);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", longint'(bus.busy), 0, 0);
        chk("midrst_done", longint'(bus.done), 0, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("midrst_out%0d", i), outv(i), 0, 0);
        reset = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("midrst_stale_done", pulses, 0, 0);
        run_op("after_rst", gid, aa, aa, 1'b0);

        // Start pulsed while busy is ignored
        @(negedge clk);
        drive(gid, aa);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        drive(gpx, aa);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        seen0 = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                seen0 = outv(0);
            end
        end
        chk("busy_start_pulses", pulses, 1, 0);
        chk("busy_start_result", seen0, A0R, 12);

        // Start held high gives back-to-back operations
        drive(gpx, aa);
        bus.start = 1'b1;
        first_d = -1;
        second_d = -1;
        gap_idle = 0;
        wide = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (prev_done) wide++;
                if (first_d < 0) first_d = i;
                else if (second_d < 0) second_d = i;
            end else if (first_d >= 0 && second_d < 0 && !bus.busy) begin
                gap_idle++;
            end
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        chk("held_first_done", longint'(first_d >= 0), 1, 0);
        chk("held_second_done", longint'(second_d >= 0), 1, 0);
        chk("held_idle_gap", gap_idle, 1, 0);
        chk("held_done_width", wide, 0, 0);
        chk("held_b0r", outv(0), A1R, 12);
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_drain", longint'(bus.busy), 0, 0);

        // Random gates and amplitudes against the exact model
        for (int t = 0; t < 30; t++) begin
            gr = rand_g();
            ar = rand_a();
            for (int i = 0; i < 4; i++)
                er[i] = model(gr, ar, i / 2, i % 2);
            run_op($sformatf("rnd%0d", t), gr, ar, er, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_pair_sequencer.md
GATE_PAIR_SEQUENCER -- requirements
Module: gate_pair_sequencer

Interface
REQ-001 SHALL have parameter NUMBER_BITS, default from shared package (37), signed fixed-point width Q1.35 (FIX_ONE = 2^35).
REQ-002 SHALL have clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have start  input  1  request to apply gate to amplitude pair; accepted only in IDLE.
REQ-005 SHALL have gate[0:1][0:1][REAL:IMAG]  input  NUMBER_BITS each  2x2 complex gate matrix U[row][col].
REQ-006 SHALL have amp_in[0:1][REAL:IMAG]  input  NUMBER_BITS each  amplitude pair (a0, a1).
REQ-007 SHALL have amp_out[0:1][REAL:IMAG]  output  NUMBER_BITS each  result pair (b0, b1).
REQ-008 SHALL have busy  output  1  high from start acceptance until done cycle inclusive.
REQ-009 SHALL have done  output  1  one-cycle pulse when amp_out is valid.

Function
REQ-010 SHALL compute b0 = U00*a0 + U01*a1, b1 = U10*a0 + U11*a1 using exactly one shared complex_fix_mul_clocked instance.
REQ-011 SHALL latch gate and amp_in on the cycle start is accepted; later input changes SHALL not affect the operation.
REQ-012 SHALL issue products in fixed order k=0..3: U00*a0, U01*a1, U10*a0, U11*a1.
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, GAP, DONE.
REQ-014 IDLE: start=1 -> latch operands, k=0, busy=1, go ISSUE; start=0 -> stay.
REQ-015 ISSUE: drive multiplier x/y with product k operands, assert multiplier ready, go WAIT.
REQ-016 WAIT: hold x/y stable and ready=1 until multiplier available=1; then capture out (NUMBER_BITS+1 wide) and go GAP.
REQ-017 GAP: deassert multiplier ready one cycle; accumulate; k<3 -> k+1, ISSUE; k=3 -> DONE.
REQ-018 Accumulation SHALL use NUMBER_BITS+2-bit signed sums per component: b0 from products 0+1, b1 from products 2+3.
REQ-019 Each sum SHALL saturate to [-2^(NUMBER_BITS-1), 2^(NUMBER_BITS-1)-1] before writing amp_out.
REQ-020 DONE: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
REQ-021 amp_out SHALL update only on entering DONE and hold until the next DONE.
REQ-022 start while busy=1 SHALL be ignored (not queued).
REQ-023 start held high SHALL begin a new operation on the cycle after DONE (back-to-back, one IDLE cycle).
REQ-024 Accuracy: each amp_out component SHALL be within +/-12 LSB of exact product sum (multiplier +/-6 LSB per product).

Reset
REQ-025 reset=0 at any rising edge SHALL force IDLE, k=0, busy=0, done=0, amp_out all 0, multiplier ready=0, from any state including mid-operation.
REQ-026 The multiplier instance SHALL receive the same clk and reset; no result captured before reset SHALL appear after it.

Structure
REQ-027 NUMBER_BITS, FIX_ONE, REAL/IMAG indices, and the state enum SHALL live in the shared types package/include.
REQ-028 Exactly one sub-module: complex_fix_mul_clocked; the saturating adder SHALL be in-line logic.

Verification
REQ-029 Identity: U=I (FIX_ONE=34359738368), a0=(13654556672, 20920401920), a1=(25615794176, 6051463168) -> amp_out equals amp_in +/-12, done one cycle, busy low after.
REQ-030 Pauli-X: U=[[0,1],[1,0]], same amplitudes -> b0=a1, b1=a0 +/-12.
REQ-031 Single product: U00=(13654556672, 20920401920), others 0, a0=(25615794176, 6051463168), a1=0 -> b0=(6495197059, 18001381437) +/-12, b1=(0,0) +/-12.
REQ-032 Saturation: U00=U01=(51539607552,0), a0=a1=(51539607552,0) -> b0 real = 68719476735, imag 0 +/-12.
REQ-033 Reset mid-op: reset=0 during WAIT of k=2 -> next cycle busy=0, done=0, amp_out=0; subsequent identity run passes REQ-029.
REQ-034 Start during busy pulsed and start held high -> no extra done during busy; held start yields back-to-back done pulses separated by DONE->IDLE->operation.
